// File: rtl/seq_detector.sv
// seq_detector: serial pattern detector with overlap mode, load, and saturating match counter
module seq_detector #(
  parameter int PAT_W = 3,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             valid,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             ovl_in,
  input  logic             clr_cnt,
  output logic             y,
  output logic [CNT_W-1:0] count,
  output logic             sat
);
  localparam int FW = $clog2(PAT_W + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_W);
  typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;
  state_t state_q, state_d;
  logic [PAT_W-1:0] hist_q, hist_d, hist_sh, pat_q, pat_d;
  logic [FW-1:0] fill_q, fill_d, fill_inc;
  logic [CNT_W-1:0] count_q, count_d;
  logic ovl_q, ovl_d, y_q, y_d, match;
  always_comb begin
    hist_sh  = {hist_q[PAT_W-2:0], x};
    fill_inc = (state_q == ARMED) ? FULL : fill_q + 1'b1;
    match    = valid && !load && hist_sh == pat_q && fill_inc == FULL;
    hist_d   = load ? '0 : valid ? hist_sh : hist_q;
    fill_d   = load ? '0 : !valid ? fill_q : (match && !ovl_q) ? '0 : fill_inc;
    pat_d    = load ? pat_in : pat_q;
    ovl_d    = load ? ovl_in : ovl_q;
    count_d  = clr_cnt ? '0 : (match && count_q != '1) ? count_q + 1'b1 : count_q;
    y_d      = match;
    state_d  = (fill_d == '0) ? IDLE : (fill_d == FULL) ? ARMED : FILL;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      hist_q  <= '0;
      fill_q  <= '0;
      pat_q   <= PAT_W'(1);
      ovl_q   <= 1'b1;
      count_q <= '0;
      y_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      count_q <= count_d;
      y_q     <= y_d;
    end
  end
  assign y     = y_q;
  assign count = count_q;
  assign sat   = &count_q;
endmodule

// File: tb/tb_seq_detector.sv
// tb_seq_detector: directed vector table plus hand-written corner sequences for seq_detector
module tb_seq_detector;
  logic clk = 1'b0;
  logic reset = 1'b1, x = 1'b0, valid = 1'b0, load = 1'b0, ovl_in = 1'b0, clr_cnt = 1'b0;
  logic [2:0] pat_in = '0;
  logic y, sat;
  logic [1:0] count;
  int checks = 0, errors = 0;

  typedef struct {
    bit rn, ld, vl, xb, ovl, clr;
    logic [2:0] pat;
    bit ey;
    int ec;
  } vec_t;
  vec_t vecs[$];

  seq_detector #(.PAT_W(3), .CNT_W(2)) dut (
    .clk(clk), .reset(reset), .x(x), .valid(valid), .load(load),
    .pat_in(pat_in), .ovl_in(ovl_in), .clr_cnt(clr_cnt),
    .y(y), .count(count), .sat(sat)
  );

  always #5 clk = ~clk;

  task automatic add(input bit rn, ld, vl, xb, input logic [2:0] p, input bit o, clr, ey, input int ec);
    vec_t v;
    v.rn = rn; v.ld = ld; v.vl = vl; v.xb = xb; v.pat = p; v.ovl = o; v.clr = clr; v.ey = ey; v.ec = ec;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic step(input string tag, input bit rn, ld, vl, xb, input logic [2:0] p, input bit o, clr, ey, input int ec);
    reset = rn; load = ld; valid = vl; x = xb; pat_in = p; ovl_in = o; clr_cnt = clr;
    @(posedge clk);
    #1;
    check({tag, ".y"}, int'(y), int'(ey));
    check({tag, ".count"}, int'(count), ec);
    check({tag, ".sat"}, int'(sat), int'(ec == 3));
  endtask

  task automatic bits(input string tag, input bit b0, b1, b2, input int c0, c1, c2, input bit y2);
    step(tag, 1, 0, 1, b0, 0, 0, 0, 0, c0);
    step(tag, 1, 0, 1, b1, 0, 0, 0, 0, c1);
    step(tag, 1, 0, 1, b2, 0, 0, 0, y2, c2);
  endtask

  initial begin
    // reset, including reset overriding load/valid/clr
    add(0,0,0,0,3'b000,0,0, 0,0);
    add(0,1,1,1,3'b111,0,1, 0,0);
    // default pattern 001 overlapping: 0,0,1,0,0,1
    add(1,0,1,0,0,0,0, 0,0);
    add(1,0,1,0,0,0,0, 0,0);
    add(1,0,1,1,0,0,0, 1,1);
    add(1,0,1,0,0,0,0, 0,1);
    add(1,0,1,0,0,0,0, 0,1);
    add(1,0,1,1,0,0,0, 1,2);
    add(1,0,0,0,0,0,1, 0,0);
    // pattern 101 overlapping: 1,0,1,0,1
    add(1,1,0,0,3'b101,1,0, 0,0);
    add(1,0,1,1,0,0,0, 0,0);
    add(1,0,1,0,0,0,0, 0,0);
    add(1,0,1,1,0,0,0, 1,1);
    add(1,0,1,0,0,0,0, 0,1);
    add(1,0,1,1,0,0,0, 1,2);
    // pattern 101 non-overlapping, with clear on the load edge
    add(1,1,0,0,3'b101,0,1, 0,0);
    add(1,0,1,1,0,0,0, 0,0);
    add(1,0,1,0,0,0,0, 0,0);
    add(1,0,1,1,0,0,0, 1,1);
    add(1,0,1,0,0,0,0, 0,1);
    add(1,0,1,1,0,0,0, 0,1);
    add(1,1,0,0,3'b001,1,1, 0,0);
    foreach (vecs[i])
      step($sformatf("vec%0d", i), vecs[i].rn, vecs[i].ld, vecs[i].vl, vecs[i].xb,
           vecs[i].pat, vecs[i].ovl, vecs[i].clr, vecs[i].ey, vecs[i].ec);

    // valid gap: x=1 while valid=0 must not be consumed
    step("gap0", 1,0,1,0,0,0,0, 0,0);
    step("gap1", 1,0,1,0,0,0,0, 0,0);
    for (int i = 0; i < 4; i++) step("gapidle", 1,0,0,1,0,0,0, 0,0);
    step("gapend", 1,0,1,1,0,0,0, 1,1);

    // saturation with CNT_W=2, then clear coinciding with a match
    step("satclr", 1,0,0,0,0,0,1, 0,0);
    bits("sat1", 0,0,1, 0,0,1, 1);
    bits("sat2", 0,0,1, 1,1,2, 1);
    bits("sat3", 0,0,1, 2,2,3, 1);
    bits("sat4", 0,0,1, 3,3,3, 1);
    bits("sat5", 0,0,1, 3,3,3, 1);
    step("clrm0", 1,0,1,0,0,0,0, 0,3);
    step("clrm1", 1,0,1,0,0,0,0, 0,3);
    step("clrm2", 1,0,1,1,0,0,1, 1,0);

    // reset mid-stream restarts detection and clears count
    bits("prerst", 0,0,1, 0,0,1, 1);
    step("rst0", 1,0,1,0,0,0,0, 0,1);
    step("rst1", 1,0,1,0,0,0,0, 0,1);
    step("rst", 0,0,1,1,0,0,0, 0,0);
    step("rstx1", 1,0,1,1,0,0,0, 0,0);
    step("rstx2", 1,0,1,0,0,0,0, 0,0);
    step("rstx3", 1,0,1,0,0,0,0, 0,0);
    step("rstx4", 1,0,1,1,0,0,0, 1,1);

    // load with valid discards x and empties history; count preserved
    step("ld0", 1,0,1,0,0,0,0, 0,1);
    step("ld1", 1,0,1,0,0,0,0, 0,1);
    step("ld", 1,1,1,1,3'b001,1,0, 0,1);
    step("ldx1", 1,0,1,0,0,0,0, 0,1);
    step("ldx2", 1,0,1,0,0,0,0, 0,1);
    step("ldx3", 1,0,1,1,0,0,0, 1,2);

    // reset pulse between edges has no effect
    reset = 1; load = 0; valid = 0; clr_cnt = 0;
    @(negedge clk);
    reset = 0;
    #2 reset = 1;
    @(posedge clk);
    #1;
    check("glitch.count", int'(count), 2);
    check("glitch.y", int'(y), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
